score_writer: RTL
=================

Name: score_writer

Overview:
- Writer side of the music score memory. Takes (tone code, beat count) pairs from a keypad or host over a valid/ready handshake.
- Expands each pair into one score-RAM word per beat and writes the words sequentially into the address region of the selected song.
- Pads the unused tail of the region with rest code 0, so the looping address counter on the read side never plays stale data.
- Sits between the input front-end and the write port of the dual-port score RAM.

Parameters:
- AW, 10, address width
- DW, 4, tone-code width
- S1_START, 0, first address of song 1
- S1_END, 138, last address of song 1
- S2_START, 139, first address of song 2
- S2_END, 335, last address of song 2

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- STATE  in  4  song select, sampled at REC_START; 4'd1 = song 1, 4'd2 = song 2
- REC_START  in  1  start-recording strobe
- REC_STOP  in  1  end-of-input request
- NOTE_VLD  in  1  note pair valid
- NOTE_RDY  out  1  writer ready to accept a pair
- NOTE_IN  in  DW  tone code
- NOTE_DUR  in  4  beats; 0 is treated as 1
- WR_EN  out  1  RAM write enable
- WR_ADDR  out  AW  RAM write address
- WR_DATA  out  DW  RAM write data
- BUSY  out  1  recording in progress
- DONE  out  1  one-cycle completion pulse
- OVF  out  1  sticky: last note truncated at region end

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous, active-high.
- Reset values: state IDLE; all outputs 0; ptr/end_ptr/rem/code registers 0.
- FSM states: IDLE, WAIT, WRITE, PAD, FIN.
- IDLE:
  - REC_START with STATE==1 loads ptr=S1_START, end_ptr=S1_END.
  - REC_START with STATE==2 loads ptr=S2_START, end_ptr=S2_END.
  - In both cases OVF clears and the next state is WAIT.
  - Any other STATE value: REC_START is ignored and the block stays in IDLE.
- WAIT:
  - NOTE_RDY = 1 only when REC_STOP = 0.
  - A pair is accepted on a cycle with NOTE_VLD & NOTE_RDY: latch code=NOTE_IN, rem=max(NOTE_DUR,1), go to WRITE.
  - REC_STOP=1 goes to PAD. Stop wins over a same-cycle NOTE_VLD; that pair is not accepted.
- WRITE:
  - Every cycle: WR_EN=1, WR_ADDR=ptr, WR_DATA=code.
  - On the edge: ptr<=ptr+1, rem<=rem-1.
  - If ptr==end_ptr: go to FIN, and set OVF=1 when rem>1.
  - Else if rem==1: go to WAIT.
  - Otherwise: stay in WRITE.
  - Result: one write per beat, back-to-back, with no gap between notes beyond the WAIT handshake cycle.
- PAD:
  - Every cycle: WR_EN=1, WR_ADDR=ptr, WR_DATA=0, ptr<=ptr+1.
  - When ptr==end_ptr (that write included): go to FIN.
  - If REC_STOP arrives when ptr has already passed end_ptr, PAD is skipped and the block goes directly to FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE.
- BUSY: 1 in WAIT, WRITE, PAD and FIN; 0 in IDLE.
- WR_EN/WR_ADDR/WR_DATA: decoded from current state and registers, zero latency. WR_ADDR=0 and WR_DATA=0 whenever WR_EN=0.
- REC_START outside IDLE: ignored. STATE changes after start: ignored.
- Region exactly filled by the last note (ptr hits end_ptr with rem==1): FIN, no pad, OVF=0.
- Pointer arithmetic: AW-bit, never wraps; the end_ptr compare always terminates first.
- Reset mid-operation: immediate return to IDLE with all outputs 0. RAM contents are left as partially written.

Test Plan:
- Basic record:
  - Stimulus: RST, then STATE=1, REC_START; pair (5,3); REC_STOP.
  - Required: writes addr 0,1,2 with data 5; then 136 writes of 0 to addr 3..138; DONE pulse one cycle after the addr-138 write; OVF=0.
- Song 2 overflow:
  - Stimulus: STATE=2; 13 pairs (7,15); then pair (9,5).
  - Required: addresses 139..333 data 7; addr 334,335 data 9; OVF=1; DONE pulse; no write above 335.
- Exact fill:
  - Stimulus: STATE=1; pairs (3,8) ×17; then pair (4,3).
  - Required: last write addr 138 data 4; no PAD writes; OVF=0.
- Handshake and simultaneity:
  - Stimulus: NOTE_VLD held across WRITE cycles; separately, NOTE_VLD and REC_STOP asserted together in WAIT.
  - Required: NOTE_RDY=0 during WRITE; in the simultaneous case the pair is not accepted and PAD starts.
- Illegal start and NOTE_DUR=0:
  - Stimulus: STATE=3 with REC_START; then STATE=1 with REC_START and pair (6,0).
  - Required: the first start leaves BUSY=0 and no writes; the second start produces a single write at addr 0 with data 6.
- Reset mid-write:
  - Stimulus: assert RST during the second beat of pair (5,4).
  - Required: WR_EN, BUSY, DONE and OVF drop to 0 asynchronously; a new REC_START restarts recording at S1_START.

Source files
------------

// File: rtl/score_writer.sv
// score_writer: expands (tone, beats) pairs into per-beat score-RAM writes
// within the selected song region, padding the unused tail with rest code 0.
module score_writer #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 4,
  parameter int unsigned S1_START = 0,
  parameter int unsigned S1_END   = 138,
  parameter int unsigned S2_START = 139,
  parameter int unsigned S2_END   = 335
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [3:0]    STATE,
  input  logic          REC_START,
  input  logic          REC_STOP,
  input  logic          NOTE_VLD,
  output logic          NOTE_RDY,
  input  logic [DW-1:0] NOTE_IN,
  input  logic [3:0]    NOTE_DUR,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output logic [DW-1:0] WR_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVF
);

  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    WRITE = 3'd2,
    PAD   = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t        st, st_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW-1:0] end_ptr, end_nxt;
  logic [BW-1:0] rem, rem_nxt;
  logic [DW-1:0] code, code_nxt;
  logic          ovf, ovf_nxt;

  assign OVF = ovf;

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st      <= IDLE;
      ptr     <= '0;
      end_ptr <= '0;
      rem     <= '0;
      code    <= '0;
      ovf     <= 1'b0;
    end else begin
      st      <= st_nxt;
      ptr     <= ptr_nxt;
      end_ptr <= end_nxt;
      rem     <= rem_nxt;
      code    <= code_nxt;
      ovf     <= ovf_nxt;
    end
  end

  // Next-state, datapath update and zero-latency output decode
  always_comb begin
    st_nxt   = st;
    ptr_nxt  = ptr;
    end_nxt  = end_ptr;
    rem_nxt  = rem;
    code_nxt = code;
    ovf_nxt  = ovf;
    NOTE_RDY = 1'b0;
    WR_EN    = 1'b0;
    WR_ADDR  = '0;
    WR_DATA  = '0;
    BUSY     = (st != IDLE);
    DONE     = 1'b0;

    case (st)
      IDLE: begin
        if (REC_START) begin
          if (STATE == 4'd1) begin
            ptr_nxt = AW'(S1_START);
            end_nxt = AW'(S1_END);
            ovf_nxt = 1'b0;
            st_nxt  = WAIT;
          end else if (STATE == 4'd2) begin
            ptr_nxt = AW'(S2_START);
            end_nxt = AW'(S2_END);
            ovf_nxt = 1'b0;
            st_nxt  = WAIT;
          end
        end
      end

      WAIT: begin
        NOTE_RDY = ~REC_STOP;
        if (REC_STOP) begin
          // Region already full: nothing left to pad
          st_nxt = (ptr > end_ptr) ? FIN : PAD;
        end else if (NOTE_VLD) begin
          code_nxt = NOTE_IN;
          rem_nxt  = (NOTE_DUR == 4'd0) ? BW'(1) : NOTE_DUR;
          st_nxt   = WRITE;
        end
      end

      WRITE: begin
        WR_EN   = 1'b1;
        WR_ADDR = ptr;
        WR_DATA = code;
        ptr_nxt = ptr + AW'(1);
        rem_nxt = rem - BW'(1);
        if (ptr == end_ptr) begin
          st_nxt = FIN;
          if (rem > BW'(1)) ovf_nxt = 1'b1;
        end else if (rem == BW'(1)) begin
          st_nxt = WAIT;
        end
      end

      PAD: begin
        WR_EN   = 1'b1;
        WR_ADDR = ptr;
        ptr_nxt = ptr + AW'(1);
        if (ptr == end_ptr) st_nxt = FIN;
      end

      FIN: begin
        DONE   = 1'b1;
        st_nxt = IDLE;
      end

      default: st_nxt = IDLE;
    endcase
  end

endmodule
